fmad_issue_queue: RTL and testbench

FMAD_ISSUE_QUEUE -- requirements
Module: fmad_issue_queue

---
 rtl/fmad_issue_queue.sv | 152 +++++++++++++++
 tb/tb_fmad_issue_queue.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmad_issue_queue.sv
// fmad_issue_queue
//   Buffers operand triples in a small FIFO and issues them one at a time to
//   an external fused multiply-add stage. A single triple is in flight at any
//   time. The result is captured and held for downstream until accepted.
//
// Ports
//   clock, reset                     : clock, async active-high reset
//   inValid/inReady                  : upstream handshake for a triple
//   inMul1, inMul2, inAdd, inSub     : triple payload (inSub=1 subtracts addend)
//   fmadMulIn1/2, fmadAddIn, sub     : registered operands to the fmad stage
//   start                            : one-cycle issue pulse to the fmad stage
//   fmadDone, fmadOut                : completion and result from the fmad stage
//   outValid/outReady, outResult     : downstream result handshake
//   count                            : FIFO occupancy
module fmad_issue_queue #(
    parameter int WIDTH    = 8,
    parameter int OUTWIDTH = 2*WIDTH,
    parameter int DEPTH    = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [WIDTH-1:0]         inMul1,
    input  logic [WIDTH-1:0]         inMul2,
    input  logic [WIDTH-1:0]         inAdd,
    input  logic                     inSub,
    output logic [WIDTH-1:0]         fmadMulIn1,
    output logic [WIDTH-1:0]         fmadMulIn2,
    output logic [WIDTH-1:0]         fmadAddIn,
    output logic                     sub,
    output logic                     start,
    input  logic                     fmadDone,
    input  logic [OUTWIDTH-1:0]      fmadOut,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [OUTWIDTH-1:0]      outResult,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] m1;
        logic [WIDTH-1:0] m2;
        logic [WIDTH-1:0] a;
        logic             s;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    entry_t              mem_q [DEPTH];
    logic [PW-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    state_t              state_q;
    logic [WIDTH-1:0]    m1_q, m2_q, a_q;
    logic                sub_q, start_q, oval_q;
    logic [OUTWIDTH-1:0] res_q;
    logic                push, pop;

    // Readiness comes from the registered count only, so a full FIFO refuses
    // a push even in the cycle it also pops.
    assign inReady = (cnt_q < CW'(DEPTH));
    assign push    = inValid && inReady;
    // Popping is tied to the IDLE->ISSUE transition: the head is loaded into
    // the operand registers on the same edge.
    assign pop     = (state_q == S_IDLE) && (cnt_q != '0);

    always_comb begin
        wr_d  = push ? wr_q + PW'(1) : wr_q;
        rd_d  = pop  ? rd_q + PW'(1) : rd_q;
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + CW'(1);
        else if (pop && !push)
            cnt_d = cnt_q - CW'(1);
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (push)
            mem_q[wr_q] <= '{m1: inMul1, m2: inMul2, a: inAdd, s: inSub};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Issue FSM with registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            m1_q    <= '0;
            m2_q    <= '0;
            a_q     <= '0;
            sub_q   <= 1'b0;
            start_q <= 1'b0;
            oval_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cnt_q != '0) begin
                        m1_q    <= mem_q[rd_q].m1;
                        m2_q    <= mem_q[rd_q].m2;
                        a_q     <= mem_q[rd_q].a;
                        sub_q   <= mem_q[rd_q].s;
                        start_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    start_q <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (fmadDone) begin
                        res_q   <= fmadOut;
                        oval_q  <= 1'b1;
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (outReady) begin
                        oval_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fmadMulIn1 = m1_q;
    assign fmadMulIn2 = m2_q;
    assign fmadAddIn  = a_q;
    assign sub        = sub_q;
    assign start      = start_q;
    assign outValid   = oval_q;
    assign outResult  = res_q;
    assign count      = cnt_q;

endmodule

// File: tb/tb_fmad_issue_queue.sv
module tb_fmad_issue_queue;
    localparam int W  = 8;
    localparam int OW = 16;
    localparam int D  = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          inValid, inReady;
    logic [W-1:0]  inMul1, inMul2, inAdd;
    logic          inSub;
    logic [W-1:0]  fmadMulIn1, fmadMulIn2, fmadAddIn;
    logic          sub, start;
    logic          fmadDone;
    logic [OW-1:0] fmadOut;
    logic          outValid, outReady;
    logic [OW-1:0] outResult;
    logic [2:0]    count;

    fmad_issue_queue #(.WIDTH(W), .OUTWIDTH(OW), .DEPTH(D)) dut (
        .clock(clock), .reset(reset),
        .inValid(inValid), .inReady(inReady),
        .inMul1(inMul1), .inMul2(inMul2), .inAdd(inAdd), .inSub(inSub),
        .fmadMulIn1(fmadMulIn1), .fmadMulIn2(fmadMulIn2), .fmadAddIn(fmadAddIn),
        .sub(sub), .start(start),
        .fmadDone(fmadDone), .fmadOut(fmadOut),
        .outValid(outValid), .outReady(outReady), .outResult(outResult),
        .count(count)
    );

    always #5 clock = ~clock;

    typedef struct {int m1; int m2; int a; bit s;} trip_t;

    trip_t opq[$];   // accepted triples awaiting issue, push order
    int    resq[$];  // expected results of issued triples, issue order
    int    vectors = 0, errs = 0;
    int    cyc = 0, last_start_cyc = -100, last_hs_cyc = -100;
    bit    fm_en = 1, fm_hold = 0;
    int    fm_lat = -1;   // <0: random latency
    int    rdy_mode = 0;  // 0 random, 1 always ready, 2 never ready

    function automatic int fmad_ref(trip_t t);
        int p = t.m1 * t.m2;
        return (t.s ? p - t.a : p + t.a) & 32'hffff;
    endfunction

    task automatic check(string name, int act, int exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // fmad stage emulation: answers each start after a latency, computing
    // from the operands the DUT actually presents.
    initial begin
        int cnt = 0, pend = 0;
        fmadDone = 1'b0;
        fmadOut  = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                cnt = 0;
            end else if (fm_en) begin
                fmadDone = 1'b0;
                if (start) begin
                    cnt  = (fm_lat > 0) ? fm_lat : int'($urandom_range(1, 4));
                    pend = fmad_ref('{int'(fmadMulIn1), int'(fmadMulIn2), int'(fmadAddIn), sub});
                end else if (cnt > 0 && !fm_hold) begin
                    cnt--;
                    if (cnt == 0) begin
                        fmadDone = 1'b1;
                        fmadOut  = OW'(pend);
                    end
                end
            end
        end
    end

    // Monitor / scoreboard, also owns outReady.
    initial begin
        bit p_start = 0, p_val = 0, p_rdy = 0;
        int p_res = 0;
        trip_t t;
        outReady = 1'b0;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                p_start = 0; p_val = 0; p_rdy = 0;
            end else begin
                if (p_val && p_rdy) last_hs_cyc = cyc;
                if (start) begin
                    last_start_cyc = cyc;
                    check("start_one_cycle", int'(p_start), 0);
                    if (opq.size() == 0) begin
                        check("unexpected_start", 1, 0);
                    end else begin
                        t = opq.pop_front();
                        check("op_mul1", int'(fmadMulIn1), t.m1);
                        check("op_mul2", int'(fmadMulIn2), t.m2);
                        check("op_add",  int'(fmadAddIn),  t.a);
                        check("op_sub",  int'(sub),        int'(t.s));
                        resq.push_back(fmad_ref(t));
                    end
                end
                if (outValid) begin
                    if (p_val && !p_rdy)
                        check("result_stable", int'(outResult), p_res);
                    else if (resq.size() == 0)
                        check("unexpected_result", 1, 0);
                    else
                        check("result", int'(outResult), resq.pop_front());
                end else if (p_val && !p_rdy) begin
                    check("valid_held", 0, 1);
                end
                case (rdy_mode)
                    1:       outReady = 1'b1;
                    2:       outReady = 1'b0;
                    default: outReady = 1'($urandom_range(0, 1));
                endcase
                p_start = start; p_val = outValid; p_rdy = outReady; p_res = int'(outResult);
            end
        end
    end

    // Drive one cycle of upstream stimulus; caller sits at a negedge.
    task automatic drive(bit v, trip_t t, output bit acc);
        inValid = v;
        inMul1  = W'(t.m1);
        inMul2  = W'(t.m2);
        inAdd   = W'(t.a);
        inSub   = t.s;
        acc     = v && inReady;
        if (acc) opq.push_back(t);
        @(negedge clock);
        inValid = 1'b0;
    endtask

    task automatic drain(string name);
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (opq.size() == 0 && resq.size() == 0 && !outValid && !start && count == 0) begin
                ok = 1;
                break;
            end
            @(negedge clock);
        end
        check(name, int'(ok), 1);
    endtask

    task automatic wait_valid(string name);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (outValid) begin ok = 1; break; end
            @(negedge clock);
        end
        check(name, int'(ok), 1);
    endtask

    initial begin
        trip_t t;
        bit    acc;
        int    n_acc, hs0;
        reset = 1'b1; inValid = 0; inMul1 = 0; inMul2 = 0; inAdd = 0; inSub = 0;
        repeat (3) @(negedge clock);
        check("rst_start",    int'(start), 0);
        check("rst_outValid", int'(outValid), 0);
        check("rst_outResult",int'(outResult), 0);
        check("rst_ops",      int'({fmadMulIn1, fmadMulIn2, fmadAddIn, sub}), 0);
        check("rst_count",    int'(count), 0);
        check("rst_inReady",  int'(inReady), 1);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_inReady", int'(inReady), 1);

        // Single add: 3*4+5 = 17
        rdy_mode = 1; fm_lat = 2;
        drive(1, '{3, 4, 5, 0}, acc);
        wait_valid("single_valid");
        check("single_result", int'(outResult), 17);
        drain("single_drain");

        // Subtract then add, results returned in push order
        drive(1, '{10, 10, 1, 1}, acc);
        drive(1, '{255, 255, 255, 0}, acc);
        drain("order_drain");

        // Full FIFO with the fmad stage stalled
        fm_hold = 1; fm_lat = 1; n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, '{i + 1, 2, 3, 0}, acc);
            n_acc += int'(acc);
        end
        check("full_accepted", n_acc, 5);
        check("full_count",    int'(count), 4);
        check("full_inReady",  int'(inReady), 0);
        fm_hold = 0; rdy_mode = 0;
        drain("full_drain");

        // Backpressure: result held, no new issue until accepted
        rdy_mode = 2; fm_lat = 1;
        drive(1, '{7, 8, 9, 0}, acc);
        drive(1, '{2, 3, 4, 1}, acc);
        wait_valid("bp_valid");
        for (int i = 0; i < 10; i++) begin
            check("bp_outValid", int'(outValid), 1);
            check("bp_no_start", int'(start), 0);
            check("bp_count",    int'(count), 1);
            @(negedge clock);
        end
        rdy_mode = 1;
        hs0 = last_start_cyc;
        for (int i = 0; i < 10 && last_start_cyc == hs0; i++) @(negedge clock);
        // Handshake edge returns to IDLE; the following edge raises start.
        check("bp_restart_gap", last_start_cyc - last_hs_cyc, 1);
        drain("bp_drain");

        // Reset while waiting on the fmad stage with two triples queued
        fm_hold = 1;
        drive(1, '{5, 5, 5, 0}, acc);
        drive(1, '{6, 6, 6, 0}, acc);
        drive(1, '{7, 7, 7, 1}, acc);
        check("wait_count", int'(count), 2);
        #2 reset = 1'b1;
        #1;
        check("arst_start",    int'(start), 0);
        check("arst_outValid", int'(outValid), 0);
        check("arst_ops",      int'({fmadMulIn1, fmadMulIn2, fmadAddIn, sub}), 0);
        check("arst_count",    int'(count), 0);
        check("arst_inReady",  int'(inReady), 1);
        opq.delete(); resq.delete();
        fm_hold = 0; fm_en = 0; fmadDone = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        fmadDone = 1'b1; fmadOut = 16'h1234;
        @(negedge clock);
        fmadDone = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("arst_late_done_valid", int'(outValid), 0);
            check("arst_no_start",        int'(start), 0);
            @(negedge clock);
        end

        // Spurious done while idle and empty
        fmadDone = 1'b1; fmadOut = 16'hbeef;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("spur_outValid", int'(outValid), 0);
            check("spur_count",    int'(count), 0);
        end
        fmadDone = 1'b0; fm_en = 1;
        @(negedge clock);

        // Random traffic
        rdy_mode = 0; fm_lat = -1;
        for (int i = 0; i < 300; i++) begin
            t = '{int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), bit'($urandom_range(0, 1))};
            drive(bit'($urandom_range(0, 99) < 55), t, acc);
        end
        drain("rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
